// File: rtl/frame_scanout_if.sv
// Renderer-to-scanout framebuffer write port.
// The renderer drives the master side; frame_scanout consumes the slave side.
interface frame_scanout_if #(
    parameter int unsigned ADDR_WIDTH = 19
);
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input wr_en, input wr_addr, input wr_data);
endinterface

// File: rtl/frame_scanout.sv
// 1-bit framebuffer with VGA scanout: counters (S0), RAM read (S1), output registers (S2).
// Emits a one-cycle frame_ce at the start of vertical blanking to pace the renderer.
module frame_scanout #(
    parameter int unsigned HOR_ACTIVE_PIXELS = 640,
    parameter int unsigned HOR_FRONT_PORCH   = 16,
    parameter int unsigned HOR_SYNC          = 96,
    parameter int unsigned HOR_BACK_PORCH    = 48,
    parameter int unsigned VER_ACTIVE_PIXELS = 480,
    parameter int unsigned VER_FRONT_PORCH   = 10,
    parameter int unsigned VER_SYNC          = 2,
    parameter int unsigned VER_BACK_PORCH    = 33,
    parameter logic        SYNC_ACTIVE_LEVEL = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    frame_scanout_if.slave  wr,
    output logic            frame_ce,
    output logic            hsync,
    output logic            vsync,
    output logic            video_on,
    output logic            pixel
);
    localparam int unsigned H_TOTAL = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC +
                                      HOR_BACK_PORCH;
    localparam int unsigned V_TOTAL = VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC +
                                      VER_BACK_PORCH;
    localparam int unsigned NUM_PIXELS    = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;
    localparam int unsigned WR_ADDR_WIDTH = $clog2(NUM_PIXELS);
    localparam int unsigned H_W  = $clog2(H_TOTAL);
    localparam int unsigned V_W  = $clog2(V_TOTAL);
    localparam int unsigned HX_W = H_W + 1;
    localparam int unsigned VX_W = V_W + 1;
    localparam int unsigned AX_W = WR_ADDR_WIDTH + 1;

    // One spare bit so sync-end bounds equal to the total still fit.
    localparam logic [HX_W-1:0] H_ACT        = HX_W'(HOR_ACTIVE_PIXELS);
    localparam logic [HX_W-1:0] H_SYNC_START = HX_W'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH);
    localparam logic [HX_W-1:0] H_SYNC_END   = HX_W'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH +
                                                     HOR_SYNC);
    localparam logic [VX_W-1:0] V_ACT        = VX_W'(VER_ACTIVE_PIXELS);
    localparam logic [VX_W-1:0] V_SYNC_START = VX_W'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH);
    localparam logic [VX_W-1:0] V_SYNC_END   = VX_W'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH +
                                                     VER_SYNC);
    localparam logic [H_W-1:0]  H_LAST       = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0]  V_LAST       = V_W'(V_TOTAL - 1);
    localparam logic [AX_W-1:0] NUM_PIX_X    = AX_W'(NUM_PIXELS);
    localparam logic            SYNC_OFF     = ~SYNC_ACTIVE_LEVEL;

    logic [H_W-1:0]           h_cnt_q, h_cnt_d;
    logic [V_W-1:0]           v_cnt_q, v_cnt_d;
    logic [WR_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                     h_wrap, v_wrap;
    logic                     active_s0, hsync_s0, vsync_s0, frame_ce_s0;
    logic                     active_d1, hsync_d1, vsync_d1;
    logic                     ram_q;
    logic                     mem [NUM_PIXELS];

    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        v_wrap  = (v_cnt_q == V_LAST);
        h_cnt_d = h_wrap ? '0 : h_cnt_q + H_W'(1);
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + V_W'(1);
        end

        active_s0   = ({1'b0, h_cnt_q} < H_ACT) && ({1'b0, v_cnt_q} < V_ACT);
        hsync_s0    = ({1'b0, h_cnt_q} >= H_SYNC_START) && ({1'b0, h_cnt_q} < H_SYNC_END);
        vsync_s0    = ({1'b0, v_cnt_q} >= V_SYNC_START) && ({1'b0, v_cnt_q} < V_SYNC_END);
        frame_ce_s0 = (h_cnt_q == '0) && ({1'b0, v_cnt_q} == V_ACT);

        // Raster-order address walk; avoids a y*width multiplier.
        rd_addr_d = rd_addr_q;
        if (h_wrap && v_wrap) begin
            rd_addr_d = '0;
        end else if (active_s0) begin
            rd_addr_d = rd_addr_q + WR_ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            rd_addr_q <= '0;
            active_d1 <= 1'b0;
            hsync_d1  <= SYNC_OFF;
            vsync_d1  <= SYNC_OFF;
            frame_ce  <= 1'b0;
            hsync     <= SYNC_OFF;
            vsync     <= SYNC_OFF;
            video_on  <= 1'b0;
            pixel     <= 1'b0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            rd_addr_q <= rd_addr_d;
            active_d1 <= active_s0;
            hsync_d1  <= hsync_s0 ? SYNC_ACTIVE_LEVEL : SYNC_OFF;
            vsync_d1  <= vsync_s0 ? SYNC_ACTIVE_LEVEL : SYNC_OFF;
            frame_ce  <= frame_ce_s0;
            hsync     <= hsync_d1;
            vsync     <= vsync_d1;
            video_on  <= active_d1;
            pixel     <= ram_q & active_d1;
        end
    end

    // Framebuffer is never reset; the read sees pre-write data on a same-address collision.
    always_ff @(posedge clk) begin
        if (wr.wr_en && ({1'b0, wr.wr_addr} < NUM_PIX_X)) begin
            mem[wr.wr_addr] <= wr.wr_data;
        end
        if (active_s0) begin
            ram_q <= mem[rd_addr_q];
        end
    end
endmodule
